// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scan-code decoder with shift/caps tracking feeding a first-word-fall-through ASCII FIFO.
// Define KEY_TYPEMATIC_FILTER_EN to suppress auto-repeat of a held key.
module ps2_key_decoder #(
    parameter int          FIFO_AW      = 3,
    parameter logic [7:0]  DEFAULT_CHAR = 8'h2a
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] scan_code,
    input  logic       scan_valid,
    input  logic       rd,
    output logic [7:0] ascii_out,
    output logic       empty,
    output logic       full,
    output logic       overflow,
    output logic       shift_on,
    output logic       caps_on
);

    localparam int DEPTH = 2 ** FIFO_AW;

    typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

    state_t state, state_next;

    logic is_prefix;
    logic make_ev, ext_make_ev, brk_ev, ext_brk_ev;
    logic lshift, rshift, caps_held;
    logic [7:0] low_char, up_char, map_char;
    logic is_letter, is_mapped, is_mod;
    logic push_req, push, do_rd, do_wr;
    logic [7:0] push_char;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   count;

    assign is_prefix = (scan_code == 8'he0) || (scan_code == 8'hf0);

    // Prefix state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (scan_valid) begin
            case (state)
                S_IDLE:    state_next = (scan_code == 8'he0) ? S_EXT :
                                        (scan_code == 8'hf0) ? S_BRK : S_IDLE;
                S_EXT:     state_next = (scan_code == 8'he0) ? S_EXT :
                                        (scan_code == 8'hf0) ? S_EXT_BRK : S_IDLE;
                S_BRK:     state_next = (scan_code == 8'hf0) ? S_BRK :
                                        (scan_code == 8'he0) ? S_EXT_BRK : S_IDLE;
                S_EXT_BRK: state_next = is_prefix ? S_EXT_BRK : S_IDLE;
                default:   state_next = S_IDLE;
            endcase
        end
    end

    // Decode the completed key event carried by a non-prefix byte
    always_comb begin
        make_ev     = 1'b0;
        ext_make_ev = 1'b0;
        brk_ev      = 1'b0;
        ext_brk_ev  = 1'b0;
        if (scan_valid && !is_prefix) begin
            case (state)
                S_IDLE:    make_ev     = 1'b1;
                S_EXT:     ext_make_ev = 1'b1;
                S_BRK:     brk_ev      = 1'b1;
                S_EXT_BRK: ext_brk_ev  = 1'b1;
                default:   make_ev     = 1'b0;
            endcase
        end
    end

    assign is_mod = (scan_code == 8'h12) || (scan_code == 8'h59) || (scan_code == 8'h58);

    // Base table: low_char is the unshifted glyph, up_char the shifted one
    always_comb begin
        low_char  = 8'h00;
        up_char   = 8'h00;
        is_letter = 1'b0;
        is_mapped = 1'b1;
        case (scan_code)
            8'h1c: begin low_char = "a"; is_letter = 1'b1; end
            8'h32: begin low_char = "b"; is_letter = 1'b1; end
            8'h21: begin low_char = "c"; is_letter = 1'b1; end
            8'h23: begin low_char = "d"; is_letter = 1'b1; end
            8'h24: begin low_char = "e"; is_letter = 1'b1; end
            8'h2b: begin low_char = "f"; is_letter = 1'b1; end
            8'h34: begin low_char = "g"; is_letter = 1'b1; end
            8'h33: begin low_char = "h"; is_letter = 1'b1; end
            8'h43: begin low_char = "i"; is_letter = 1'b1; end
            8'h3b: begin low_char = "j"; is_letter = 1'b1; end
            8'h42: begin low_char = "k"; is_letter = 1'b1; end
            8'h4b: begin low_char = "l"; is_letter = 1'b1; end
            8'h3a: begin low_char = "m"; is_letter = 1'b1; end
            8'h31: begin low_char = "n"; is_letter = 1'b1; end
            8'h44: begin low_char = "o"; is_letter = 1'b1; end
            8'h4d: begin low_char = "p"; is_letter = 1'b1; end
            8'h15: begin low_char = "q"; is_letter = 1'b1; end
            8'h2d: begin low_char = "r"; is_letter = 1'b1; end
            8'h1b: begin low_char = "s"; is_letter = 1'b1; end
            8'h2c: begin low_char = "t"; is_letter = 1'b1; end
            8'h3c: begin low_char = "u"; is_letter = 1'b1; end
            8'h2a: begin low_char = "v"; is_letter = 1'b1; end
            8'h1d: begin low_char = "w"; is_letter = 1'b1; end
            8'h22: begin low_char = "x"; is_letter = 1'b1; end
            8'h35: begin low_char = "y"; is_letter = 1'b1; end
            8'h1a: begin low_char = "z"; is_letter = 1'b1; end
            8'h16: begin low_char = "1"; up_char = "!";  end
            8'h1e: begin low_char = "2"; up_char = "@";  end
            8'h26: begin low_char = "3"; up_char = "#";  end
            8'h25: begin low_char = "4"; up_char = "$";  end
            8'h2e: begin low_char = "5"; up_char = "%";  end
            8'h36: begin low_char = "6"; up_char = "^";  end
            8'h3d: begin low_char = "7"; up_char = "&";  end
            8'h3e: begin low_char = "8"; up_char = "*";  end
            8'h46: begin low_char = "9"; up_char = "(";  end
            8'h45: begin low_char = "0"; up_char = ")";  end
            8'h0e: begin low_char = 8'h60; up_char = "~";  end
            8'h4e: begin low_char = "-"; up_char = "_";  end
            8'h55: begin low_char = "="; up_char = "+";  end
            8'h54: begin low_char = "["; up_char = "{";  end
            8'h5b: begin low_char = "]"; up_char = "}";  end
            8'h5d: begin low_char = "\\"; up_char = "|"; end
            8'h4c: begin low_char = ";"; up_char = ":";  end
            8'h52: begin low_char = "'"; up_char = "\""; end
            8'h41: begin low_char = ","; up_char = "<";  end
            8'h49: begin low_char = "."; up_char = ">";  end
            8'h4a: begin low_char = "/"; up_char = "?";  end
            8'h29: begin low_char = 8'h20; up_char = 8'h20; end
            8'h5a: begin low_char = 8'h0d; up_char = 8'h0d; end
            8'h66: begin low_char = 8'h08; up_char = 8'h08; end
            default: is_mapped = 1'b0;
        endcase
        if (is_letter) up_char = low_char - 8'h20;
    end

    always_comb begin
        if (is_letter) map_char = (shift_on ^ caps_on) ? up_char : low_char;
        else           map_char = shift_on ? up_char : low_char;
    end

    always_comb begin
        push_req  = 1'b0;
        push_char = 8'h00;
        if (make_ev && !is_mod) begin
            push_req  = 1'b1;
            push_char = is_mapped ? map_char : DEFAULT_CHAR;
        end else if (ext_make_ev && scan_code == 8'h5a) begin
            push_req  = 1'b1;
            push_char = 8'h0d;
        end else if (ext_make_ev && scan_code == 8'h4a) begin
            push_req  = 1'b1;
            push_char = 8'h2f;
        end
    end

`ifdef KEY_TYPEMATIC_FILTER_EN
    logic       last_valid, last_ext;
    logic [7:0] last_code;
    logic       repeat_hit;

    assign repeat_hit = last_valid && (last_code == scan_code) && (last_ext == ext_make_ev);
    assign push       = push_req && !repeat_hit;

    // Any make overwrites the record; only keys that produce characters keep it valid
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_valid <= 1'b0;
            last_ext   <= 1'b0;
            last_code  <= 8'h00;
        end else if (make_ev || ext_make_ev) begin
            last_valid <= push_req;
            last_ext   <= ext_make_ev;
            last_code  <= scan_code;
        end else if ((brk_ev || ext_brk_ev) && last_code == scan_code && last_ext == ext_brk_ev) begin
            last_valid <= 1'b0;
        end
    end
`else
    assign push = push_req;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lshift    <= 1'b0;
            rshift    <= 1'b0;
            caps_held <= 1'b0;
            caps_on   <= 1'b0;
        end else if (make_ev) begin
            if (scan_code == 8'h12) lshift <= 1'b1;
            if (scan_code == 8'h59) rshift <= 1'b1;
            if (scan_code == 8'h58) begin
                if (!caps_held) caps_on <= ~caps_on;
                caps_held <= 1'b1;
            end
        end else if (brk_ev) begin
            if (scan_code == 8'h12) lshift    <= 1'b0;
            if (scan_code == 8'h59) rshift    <= 1'b0;
            if (scan_code == 8'h58) caps_held <= 1'b0;
        end
    end

    assign shift_on = lshift | rshift;

    assign empty = (count == '0);
    assign full  = (count == DEPTH[FIFO_AW:0]);
    assign do_rd = rd && !empty;
    // A read frees a slot in the same cycle, so a full FIFO still accepts the push
    assign do_wr = push && (!full || do_rd);

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= push_char;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            if (do_wr && !do_rd)      count <= count + 1'b1;
            else if (do_rd && !do_wr) count <= count - 1'b1;
            overflow <= push && !do_wr;
        end
    end

    assign ascii_out = empty ? 8'h00 : mem[rd_ptr];

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
Sequential successor to the scan-code lookup: consumes the PS/2 set-2 scan-code stream (make, F0 break and E0 extended prefixes) and tracks shift and caps-lock state. It emits case-correct and shift-correct ASCII into a parametrised first-word-fall-through FIFO. It sits between the PS/2 receiver (scan_valid = receiver done tick) and the text/UART consumer.

Parameters:
FIFO_AW, 3, FIFO address width; depth = 2**FIFO_AW entries of 8 bits
DEFAULT_CHAR, 8'h2a, ASCII pushed for an unmapped non-extended make code

Ports:
clk  input  1  system clock, all logic on rising edge
reset_n  input  1  asynchronous active-low reset
scan_code  input  8  received scan byte, valid only with scan_valid
scan_valid  input  1  one-cycle strobe, one byte per strobe
rd  input  1  pop request for the FIFO head
ascii_out  output  8  FIFO head (FWFT); meaningful only when empty=0
empty  output  1  FIFO holds no characters
full  output  1  FIFO holds 2**FIFO_AW characters
overflow  output  1  one-cycle pulse when a character is dropped because the FIFO is full
shift_on  output  1  left or right shift currently held
caps_on  output  1  caps-lock toggle state

Behaviour:
- Reset (async assert, sync-free release): FIFO pointers and count = 0, empty=1, full=0, overflow=0, prefix FSM=IDLE, shift/caps/held flags=0, ascii_out=8'h00.
- Prefix FSM states: IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0). Transitions occur only on scan_valid.
  - IDLE: E0->EXT, F0->BRK, other byte->make, stay IDLE.
  - EXT: E0 stays EXT, F0->EXT_BRK, other byte->extended make ->IDLE.
  - BRK: F0 stays BRK, E0->EXT_BRK, other byte->break ->IDLE.
  - EXT_BRK: E0/F0 stay EXT_BRK, other byte->extended break ->IDLE.
- Modifiers (non-extended codes): 12=lshift, 59=rshift.
  - A make sets the matching held flag; a break clears it. shift_on = lshift|rshift.
  - 58=caps: a make toggles caps_on only if caps_held=0, then sets caps_held. A caps break clears caps_held, so typematic caps repeats do not toggle.
  - Modifiers never push characters.
- Make mapping (non-extended): same base table as the existing lookup.
  - Letters: uppercase (41-5A) when shift_on XOR caps_on, otherwise lowercase (+8'h20).
  - Digits/punctuation with shift_on=1:
    - 1! 2@ 3# 4$ 5% 6^ 7& 8* 9( 0)
    - `~ -_ =+ [{ ]} \| ;: '" ,< .> /?
  - Caps has no effect on digits/punctuation.
  - Space 20, enter 0D, backspace 08 are shift-independent.
  - Unmapped make pushes DEFAULT_CHAR.
- Extended makes: E0 5A->0D, E0 4A->2F; all others ignored. All breaks push nothing.
- Modifier state used is the value before the current byte.
- Latency: a make on scan_valid in cycle N is written at the end of cycle N; empty=0 and ascii_out valid in cycle N+1.
- FIFO:
  - rd while empty is ignored.
  - A push while full is dropped, overflow pulses, and the FIFO is unchanged.
  - Simultaneous push and rd while full: both occur, count unchanged, no overflow.
  - Simultaneous push and rd while empty: the push occurs and rd is ignored.
  - Pointers wrap modulo depth.
- Reset mid-sequence (e.g. after F0) discards the pending prefix and all state.

Optional Feature:
KEY_TYPEMATIC_FILTER_EN
- Defined: the decoder records the last mapped make code and its extended bit. A repeated identical make with no intervening break of that key pushes nothing. The record clears on that key's break or on any different make.
- Undefined: every typematic repeat pushes a character.
- Modifier handling is identical in both builds.

Test Plan:
- Reset, then scan 1C, F0 1C -> one entry 61 ('a'); empty=0 in the cycle after the 1C strobe; after rd, empty=1.
- Scan 12, 1C, F0 1C, F0 12, 1C -> FIFO holds 41 then 61; shift_on=1 between the 12 and F0 12.
- Scan 58, F0 58, 1C, 16 -> caps_on=1, FIFO 41, 31. Add 12 then 1C, 16 -> 61, 21.
- Scan E0 5A, E0 F0 5A, E0 75 -> single entry 0D; FSM back in IDLE; no entry for 75.
- FIFO_AW=2: push 5 makes of 16 with no rd -> full=1 after 4, overflow pulses once, head still 31. Pop 4 -> empty=1.
- With KEY_TYPEMATIC_FILTER_EN: scan 1C,1C,1C, F0 1C, 1C -> 61, 61. Without the macro -> four 61 entries.
